// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared definitions for the instruction-fetch / data-access RAM
//            arbiter: default geometry, arbiter state encoding and a helper
//            that sizes the starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int c_DEF_ADDR_W     = 10;
    localparam int c_DEF_STARVE_MAX = 4;

    // Arbiter states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_IF  = 2'd1,
        ST_WAIT_MEM = 2'd2
    } arb_state_t;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the fetch port, data port and RAM port of the arbiter.
// Ports    : fetch  - if_req/if_addr in, if_rdata/if_ready/stall_if out
//            data   - mem_req/mem_we/mem_addr/mem_wdata in,
//                     mem_rdata/mem_ready/mem_err/stall_mem out
//            RAM    - ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in
//            modport slave  : arbiter view
//            modport master : requester / RAM model view
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W
) ();

    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready;
    logic              stall_if;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;
    logic              mem_err;
    logic              stall_mem;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  ram_rdata,
        output if_rdata, if_ready, stall_if,
        output mem_rdata, mem_ready, mem_err, stall_mem,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output ram_rdata,
        input  if_rdata, if_ready, stall_if,
        input  mem_rdata, mem_ready, mem_err, stall_mem,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : starve_ctr
// Purpose  : Counts consecutive data-port wins taken while a fetch waits.
//            Saturates at STARVE_MAX; o_at_max tells the arbiter to let the
//            fetch win the next contested grant.
// Ports    : clk, rst   - clock, asynchronous active-high reset
//            i_inc      - data grant while fetch is requesting
//            i_clr      - fetch grant
//            o_at_max   - count has reached STARVE_MAX
// Revision : 1.0 - initial release
// ============================================================================
module starve_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = c_DEF_STARVE_MAX,
    parameter int CNT_W      = cnt_width(STARVE_MAX)
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_inc,
    input  wire logic i_clr,
    output logic      o_at_max
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_max = (r_cnt == c_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port synchronous RAM between an instruction
//            fetch port and a data load/store port. The data port normally
//            wins; after STARVE_MAX contested data wins the fetch port is
//            forced through. Each access takes a grant cycle (RAM strobed
//            combinationally) followed by a completion cycle (ready pulse).
// Ports    : clk        - clock
//            rst        - asynchronous active-high reset
//            bus        - mem_arbiter_if.slave (fetch, data and RAM ports)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int STARVE_MAX = c_DEF_STARVE_MAX
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t r_state;
    logic       r_if_ready;
    logic       r_mem_ready;
    logic       r_mem_err;

    logic       w_idle;
    logic       w_starved;
    logic       w_grant_mem;
    logic       w_grant_if;
    logic       w_mem_misaligned;
    logic       w_unused;

    // Gating with rst keeps the RAM strobe low during the reset cycle itself.
    assign w_idle           = (r_state == ST_IDLE) && !rst;
    assign w_mem_misaligned = |bus.mem_addr[1:0];

    // Data wins unless the fetch port is both waiting and starved.
    assign w_grant_mem = w_idle && bus.mem_req && !(bus.if_req && w_starved);
    assign w_grant_if  = w_idle && bus.if_req && !w_grant_mem;

    starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_grant_mem && bus.if_req),
        .i_clr    (w_grant_if),
        .o_at_max (w_starved)
    );

    // RAM port is driven straight from the winning requester in the grant cycle.
    always_comb begin
        bus.ram_en    = w_grant_mem || w_grant_if;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        if (w_grant_mem) begin
            // A misaligned store is turned into a harmless read.
            bus.ram_we    = bus.mem_we && !w_mem_misaligned;
            bus.ram_addr  = bus.mem_addr[ADDR_W+1:2];
            bus.ram_wdata = bus.mem_wdata;
        end else if (w_grant_if) begin
            bus.ram_addr  = bus.if_addr[ADDR_W+1:2];
        end
    end

    // Ready/error flags are set on the grant edge, so they are high exactly
    // while the FSM sits in the matching WAIT state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_mem_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_mem) begin
                        r_state     <= ST_WAIT_MEM;
                        r_mem_ready <= 1'b1;
                        r_mem_err   <= w_mem_misaligned;
                    end else if (w_grant_if) begin
                        r_state     <= ST_WAIT_IF;
                        r_if_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ready  = r_if_ready;
    assign bus.mem_ready = r_mem_ready;
    assign bus.mem_err   = r_mem_err;
    assign bus.if_rdata  = bus.ram_rdata;
    assign bus.mem_rdata = bus.ram_rdata;
    assign bus.stall_if  = bus.if_req  && !r_if_ready  && !rst;
    assign bus.stall_mem = bus.mem_req && !r_mem_ready && !rst;

    // Byte-lane and out-of-range address bits do not select a RAM word.
    assign w_unused = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                        bus.mem_addr[31:ADDR_W+2]};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a behavioural RAM.
//            Single-requester transactions come from a vector table; the
//            contention, starvation and reset corner cases are hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int c_ADDR_W = 10;
    localparam int c_NVEC   = 10;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(c_ADDR_W)) bus ();

    mem_arbiter #(
        .ADDR_W     (c_ADDR_W),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Read-first synchronous RAM: data appears the cycle after ram_en.
    logic [31:0] ram [0:(1<<c_ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= ram[bus.ram_addr];
        end
    end

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        exp_mem;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [c_NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic mr,
                         input logic mwe, input logic [31:0] ma, input logic [31:0] mwd);
        bus.if_req    = ifr;
        bus.if_addr   = ifa;
        bus.mem_req   = mr;
        bus.mem_we    = mwe;
        bus.mem_addr  = ma;
        bus.mem_wdata = mwd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_m [10];

        for (int i = 0; i < (1<<c_ADDR_W); i++) ram[i] = {16'hC0DE, 16'(i)};
        ram[4] = 32'hDEADBEEF;
        bus.ram_rdata = '0;
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        //                 ifr   if_addr        mr    we    mem_addr      wdata          mem   addr    we    rdata          err
        vecs[0] = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 32'd4,   1'b0, 32'hDEADBEEF,  1'b0};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'd8,   1'b0, 32'hC0DE0008,  1'b0};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0003, 32'h12345678, 1'b1, 32'd0,   1'b0, 32'hC0DE0000,  1'b1};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'd0,   1'b0, 32'hC0DE0000,  1'b0};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0040, 32'hCAFEF00D, 1'b1, 32'd16,  1'b1, 32'hC0DE0010,  1'b0};
        vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0040, 32'h0,        1'b1, 32'd16,  1'b0, 32'hCAFEF00D,  1'b0};
        vecs[6] = '{1'b1, 32'h0000_0043, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 32'd16,  1'b0, 32'hCAFEF00D,  1'b0};
        vecs[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        1'b1, 32'h3FF, 1'b0, 32'hC0DE03FF,  1'b0};
        vecs[8] = '{1'b1, 32'h1000_0010, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 32'd4,   1'b0, 32'hDEADBEEF,  1'b0};
        vecs[9] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0042, 32'h0,        1'b1, 32'd16,  1'b0, 32'hCAFEF00D,  1'b1};

        // Reset state
        rst = 1'b1;
        #2;
        chk("rst_ram_en",    32'(bus.ram_en),    32'd0);
        chk("rst_if_ready",  32'(bus.if_ready),  32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_mem_err",   32'(bus.mem_err),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table: one requester per transaction, all from IDLE
        for (int v = 0; v < c_NVEC; v++) begin
            @(negedge clk);
            chk("idle_ram_en", 32'(bus.ram_en), 32'd0);
            drive(vecs[v].if_req, vecs[v].if_addr, vecs[v].mem_req,
                  vecs[v].mem_we, vecs[v].mem_addr, vecs[v].mem_wdata);
            #1;
            chk($sformatf("v%0d_grant_en", v), 32'(bus.ram_en),   32'd1);
            chk($sformatf("v%0d_addr", v),     32'(bus.ram_addr), vecs[v].exp_addr);
            chk($sformatf("v%0d_we", v),       32'(bus.ram_we),   32'(vecs[v].exp_we));
            chk($sformatf("v%0d_stall", v),
                32'(vecs[v].exp_mem ? bus.stall_mem : bus.stall_if), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_wait_en", v),  32'(bus.ram_en),    32'd0);
            chk($sformatf("v%0d_if_rdy", v),   32'(bus.if_ready),  32'(!vecs[v].exp_mem));
            chk($sformatf("v%0d_mem_rdy", v),  32'(bus.mem_ready), 32'(vecs[v].exp_mem));
            chk($sformatf("v%0d_err", v),      32'(bus.mem_err),   32'(vecs[v].exp_err));
            chk($sformatf("v%0d_rdata", v),
                vecs[v].exp_mem ? bus.mem_rdata : bus.if_rdata, vecs[v].exp_rdata);
            chk($sformatf("v%0d_stall_done", v),
                32'(vecs[v].exp_mem ? bus.stall_mem : bus.stall_if), 32'd0);
            drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        end

        // Simultaneous requests: data first, fetch two cycles later
        @(negedge clk);
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, '0);
        #1;
        chk("both_c0_addr",      32'(bus.ram_addr),  32'd8);
        chk("both_c0_stall_if",  32'(bus.stall_if),  32'd1);
        @(negedge clk);
        chk("both_c1_mem_rdy",   32'(bus.mem_ready), 32'd1);
        chk("both_c1_if_rdy",    32'(bus.if_ready),  32'd0);
        chk("both_c1_rdata",     bus.mem_rdata,      32'hC0DE0008);
        bus.mem_req = 1'b0;
        @(negedge clk);
        chk("both_c2_en",        32'(bus.ram_en),    32'd1);
        chk("both_c2_addr",      32'(bus.ram_addr),  32'd4);
        @(negedge clk);
        chk("both_c3_if_rdy",    32'(bus.if_ready),  32'd1);
        chk("both_c3_mem_rdy",   32'(bus.mem_ready), 32'd0);
        chk("both_c3_rdata",     bus.if_rdata,       32'hDEADBEEF);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Both held continuously: fetch forced through after four data wins
        exp_m = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        @(negedge clk);
        drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, '0);
        for (int g = 0; g < 10; g++) begin
            #1;
            chk($sformatf("starve_g%0d_addr", g), 32'(bus.ram_addr), exp_m[g] ? 32'd8 : 32'd4);
            @(negedge clk);
            chk($sformatf("starve_g%0d_mem_rdy", g), 32'(bus.mem_ready), 32'(exp_m[g]));
            chk($sformatf("starve_g%0d_if_rdy", g),  32'(bus.if_ready),  32'(!exp_m[g]));
            @(negedge clk);
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of a data access
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 1'b0, 32'h40, '0);
        #1;
        chk("rstw_grant_en", 32'(bus.ram_en), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstw_mem_rdy", 32'(bus.mem_ready), 32'd0);
        chk("rstw_ram_en",  32'(bus.ram_en),    32'd0);
        bus.mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstw_idle_en",  32'(bus.ram_en),    32'd0);
        chk("rstw_idle_rdy", 32'(bus.mem_ready), 32'd0);
        drive(1'b0, '0, 1'b1, 1'b0, 32'h40, '0);
        #1;
        chk("rstw_post_en",   32'(bus.ram_en),   32'd1);
        chk("rstw_post_addr", 32'(bus.ram_addr), 32'd16);
        @(negedge clk);
        chk("rstw_post_rdy",   32'(bus.mem_ready), 32'd1);
        chk("rstw_post_rdata", bus.mem_rdata,      32'hCAFEF00D);
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the shared RAM (byte address bits [ADDR_W+1:2]).
REQ-002 Parameter STARVE_MAX, default 4, consecutive MEM grants won over a waiting IF before IF is forced to win.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 if_req  input  1  fetch request, held until if_ready.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata  output  32  fetch data, valid when if_ready.
REQ-008 if_ready  output  1  one-cycle completion pulse for fetch.
REQ-009 mem_req  input  1  data-access request, held until mem_ready.
REQ-010 mem_we  input  1  1 = store, 0 = load.
REQ-011 mem_addr  input  32  data byte address.
REQ-012 mem_wdata  input  32  store data.
REQ-013 mem_rdata  output  32  load data, valid when mem_ready.
REQ-014 mem_ready  output  1  one-cycle completion pulse for data access.
REQ-015 mem_err  output  1  pulses with mem_ready when mem_addr[1:0] != 0.
REQ-016 ram_en  output  1  RAM access strobe.
REQ-017 ram_we  output  1  RAM write enable.
REQ-018 ram_addr  output  ADDR_W  RAM word address.
REQ-019 ram_wdata  output  32  RAM write data.
REQ-020 ram_rdata  input  32  RAM read data, valid the cycle after ram_en.
REQ-021 stall_if, stall_mem  output  1 each  = req & ~ready of the respective port.

Function
REQ-022 FSM states IDLE, WAIT_IF, WAIT_MEM; reset state IDLE.
REQ-023 IDLE, no req: ram_en=0, stay IDLE.
REQ-024 IDLE, grant: ram_en=1 combinationally that cycle, ram_addr/ram_we/ram_wdata from granted port; go WAIT_IF or WAIT_MEM.
REQ-025 Priority: MEM over IF, except IF wins when both request and starve_cnt == STARVE_MAX.
REQ-026 starve_cnt: +1 on each MEM grant while if_req=1, saturating at STARVE_MAX; cleared on IF grant.
REQ-027 WAIT_x: ram_en=0; x_ready=1, x_rdata=ram_rdata; return to IDLE (one access per 2 cycles; grant-to-ready latency 1).
REQ-028 Stores also pass through WAIT_MEM; mem_rdata undefined-but-driven (ram_rdata) on store completion.
REQ-029 Misaligned MEM access: ram_we forced 0 in grant cycle, mem_err=1 with mem_ready; IF addresses always treated as aligned (bits [1:0] ignored).
REQ-030 Request dropped during WAIT: completion pulse still issued, no retry.
REQ-031 Outputs if_ready, mem_ready, mem_err are 0 outside WAIT states; never both readies in one cycle.

Reset
REQ-032 rst asserted: state=IDLE, starve_cnt=0, all outputs 0 (rdata outputs may follow ram_rdata but readies 0) within same cycle.
REQ-033 Reset mid-WAIT drops the in-flight access with no ready pulse; requester must re-present after rst deasserts.

Structure
REQ-034 Shared package holds the state enum and default ADDR_W; no sub-module required beyond optional starve counter module starve_ctr.

Verification
REQ-035 IF only, if_addr=0x10, RAM word 4 = 0xDEADBEEF -> ram_en cycle 0 addr 4, if_ready cycle 1 with 0xDEADBEEF, stall_if high cycle 0 only.
REQ-036 if_req and mem_req (load 0x20) together -> MEM granted first (ram_addr 8), IF granted at cycle 2, if_ready cycle 3.
REQ-037 Both held continuously, STARVE_MAX=4 -> grant order MEM,MEM,MEM,MEM,IF,MEM... ; starve_cnt back to 0 after IF grant.
REQ-038 Store 0x12345678 to 0x3 -> ram_we=0, mem_err=1 with mem_ready; subsequent load of word 0 returns prior contents.
REQ-039 rst asserted during WAIT_MEM -> no mem_ready, state IDLE, ram_en=0 next cycle; post-reset request served normally.
